// File: rtl/execute_mc.sv
// Registered execute stage: forwarding, ALU, branch/jump resolution and an
// iterative shift-add multiplier behind a valid/ready output register.
// Optional signed-overflow flag on out_ovf is enabled by defining EXEC_OVF_EN.
module execute_mc #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] pc_inc,
  input  logic [WIDTH-1:0] read1,
  input  logic [WIDTH-1:0] read2,
  input  logic [WIDTH-1:0] imm,
  input  logic             use_imm,
  input  logic             fwd_a_en,
  input  logic [WIDTH-1:0] fwd_data,
  input  logic             br_en,
  input  logic [1:0]       br_cond,
  input  logic             jmp_en,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_result,
  output logic [WIDTH-1:0] out_pc_next,
  output logic             out_pc_src,
  output logic             out_ovf,
  output logic             dbg_state
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MUL  = 1'b1;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_OR    = 3'b011;
  localparam logic [2:0] OP_XOR   = 3'b100;
  localparam logic [2:0] OP_SLT   = 3'b101;
  localparam logic [2:0] OP_PASSB = 3'b110;
  localparam logic [2:0] OP_MUL   = 3'b111;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] pc_target;
  logic             slt;
  logic             cond_met;
  logic             pc_src_c;
  logic             alu_ovf;

  logic [WIDTH-1:0] mul_a;
  logic [WIDTH-1:0] mul_b;
  logic [WIDTH-1:0] mul_acc;
  logic [WIDTH-1:0] mul_step;
  logic [WIDTH-1:0] mul_res;
  logic [WIDTH-1:0] mul_pc_next;
  logic             mul_pc_src;

  logic slot_free;
  logic accept;
  logic accept_mul;
  logic accept_alu;
  logic mul_last;
  logic mul_done;

  // Handshake: an op transfers in when in_valid & in_ready at a clock edge;
  // a result transfers out when out_valid & out_ready at a clock edge.
  // Neither valid may depend on the matching ready.
  assign slot_free  = ~out_valid | out_ready;
  assign in_ready   = (state == S_IDLE) & slot_free & ~flush;
  assign accept     = in_valid & in_ready;
  assign accept_mul = accept & (op == OP_MUL);
  assign accept_alu = accept & (op != OP_MUL);
  assign dbg_state  = state;

  assign opa       = fwd_a_en ? fwd_data : read1;
  assign opb       = use_imm ? imm : read2;
  assign sum       = opa + opb;
  assign diff      = opa + ~opb + WIDTH'(1);
  assign slt       = $signed(opa) < $signed(opb);
  assign pc_target = pc_inc + imm;

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:   alu_res = sum;
      OP_SUB:   alu_res = diff;
      OP_AND:   alu_res = opa & opb;
      OP_OR:    alu_res = opa | opb;
      OP_XOR:   alu_res = opa ^ opb;
      OP_SLT:   alu_res = {{(WIDTH-1){1'b0}}, slt};
      OP_PASSB: alu_res = opb;
      default:  alu_res = '0;
    endcase
  end

  always_comb begin
    cond_met = 1'b0;
    case (br_cond)
      2'b00:   cond_met = (opa == '0);
      2'b01:   cond_met = (opa != '0);
      2'b10:   cond_met = opa[WIDTH-1];
      default: cond_met = ~opa[WIDTH-1];
    endcase
  end

  assign pc_src_c = jmp_en | (br_en & cond_met);

  // The final multiply step is folded into the result so that a stall at the
  // last count never accumulates twice.
  assign mul_step = mul_b[0] ? mul_a : '0;
  assign mul_res  = mul_acc + mul_step;
  assign mul_last = (state == S_MUL) && (cnt == CNT_LAST);
  assign mul_done = mul_last & slot_free & ~flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      mul_a       <= '0;
      mul_b       <= '0;
      mul_acc     <= '0;
      mul_pc_next <= '0;
      mul_pc_src  <= 1'b0;
    end else if (flush) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else if (accept_mul) begin
      state       <= S_MUL;
      cnt         <= '0;
      mul_a       <= opa;
      mul_b       <= opb;
      mul_acc     <= '0;
      mul_pc_next <= pc_target;
      mul_pc_src  <= pc_src_c;
    end else if (state == S_MUL) begin
      if (!mul_last) begin
        cnt     <= cnt + CNT_W'(1);
        mul_acc <= mul_res;
        mul_a   <= mul_a << 1;
        mul_b   <= mul_b >> 1;
      end else if (mul_done) begin
        state <= S_IDLE;
        cnt   <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_pc_next <= '0;
      out_pc_src  <= 1'b0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      out_pc_src <= 1'b0;
    end else if (accept_alu) begin
      out_valid   <= 1'b1;
      out_result  <= alu_res;
      out_pc_next <= pc_target;
      out_pc_src  <= pc_src_c;
    end else if (mul_done) begin
      out_valid   <= 1'b1;
      out_result  <= mul_res;
      out_pc_next <= mul_pc_next;
      out_pc_src  <= mul_pc_src;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
      out_pc_src <= 1'b0;
    end
  end

`ifdef EXEC_OVF_EN
  // Signed wrap: same-sign operands (ADD) or opposite-sign (SUB) whose result
  // sign differs from A.
  always_comb begin
    alu_ovf = 1'b0;
    if (op == OP_ADD)
      alu_ovf = (opa[WIDTH-1] == opb[WIDTH-1]) && (sum[WIDTH-1] != opa[WIDTH-1]);
    else if (op == OP_SUB)
      alu_ovf = (opa[WIDTH-1] != opb[WIDTH-1]) && (diff[WIDTH-1] != opa[WIDTH-1]);
  end

  always_ff @(posedge clk) begin
    if (rst)
      out_ovf <= 1'b0;
    else if (flush)
      out_ovf <= 1'b0;
    else if (accept_alu)
      out_ovf <= alu_ovf;
    else if (mul_done)
      out_ovf <= 1'b0;
  end
`else
  assign alu_ovf = 1'b0;
  assign out_ovf = alu_ovf;
`endif

endmodule

// File: tb/tb_execute_mc.sv
// Bench for execute_mc: directed scenarios plus random traffic, checked by a
// scoreboard queue fed from an arithmetic reference model.
module tb_execute_mc;
  localparam int W  = 16;
  localparam int CW = 5;
  localparam int EW = 2 * W + 2;
  localparam longint MAXS = (longint'(1) << (W - 1)) - 1;
  localparam longint MINS = -(longint'(1) << (W - 1));
`ifdef EXEC_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   op = '0;
  logic [W-1:0] pc_inc = '0;
  logic [W-1:0] read1 = '0;
  logic [W-1:0] read2 = '0;
  logic [W-1:0] imm = '0;
  logic         use_imm = 1'b0;
  logic         fwd_a_en = 1'b0;
  logic [W-1:0] fwd_data = '0;
  logic         br_en = 1'b0;
  logic [1:0]   br_cond = '0;
  logic         jmp_en = 1'b0;
  logic         out_ready = 1'b1;
  logic         out_valid;
  logic [W-1:0] out_result;
  logic [W-1:0] out_pc_next;
  logic         out_pc_src;
  logic         out_ovf;
  logic         dbg_state;

  logic [EW-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  execute_mc #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .pc_inc(pc_inc), .read1(read1), .read2(read2), .imm(imm),
    .use_imm(use_imm), .fwd_a_en(fwd_a_en), .fwd_data(fwd_data),
    .br_en(br_en), .br_cond(br_cond), .jmp_en(jmp_en), .out_ready(out_ready),
    .out_valid(out_valid), .out_result(out_result), .out_pc_next(out_pc_next),
    .out_pc_src(out_pc_src), .out_ovf(out_ovf), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Reference model: {result, pc_next, pc_src, ovf}
  function automatic logic [EW-1:0] model(input logic [2:0] o, input logic [W-1:0] a,
      input logic [W-1:0] b, input logic [W-1:0] pc, input logic [W-1:0] im,
      input logic br, input logic [1:0] bc, input logic jmp);
    longint sa, sb, sr;
    logic [W-1:0] r, pcn;
    logic ov, taken;
    sa = longint'(a) - (a[W-1] ? (longint'(1) << W) : longint'(0));
    sb = longint'(b) - (b[W-1] ? (longint'(1) << W) : longint'(0));
    ov = 1'b0;
    r = '0;
    case (o)
      3'd0: begin sr = sa + sb; r = W'(sr); ov = (sr > MAXS) || (sr < MINS); end
      3'd1: begin sr = sa - sb; r = W'(sr); ov = (sr > MAXS) || (sr < MINS); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r[0] = (sa < sb);
      3'd6: r = b;
      default: r = W'(longint'(a) * longint'(b));
    endcase
    case (bc)
      2'd0: taken = (sa == 0);
      2'd1: taken = (sa != 0);
      2'd2: taken = (sa < 0);
      default: taken = (sa >= 0);
    endcase
    pcn = W'(longint'(pc) + longint'(im));
    return {r, pcn, jmp | (br & taken), ov & OVF_ON};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Driver tasks: set signals right after a negedge, then call apply.
  task automatic idle_inputs();
    in_valid = 1'b0; flush = 1'b0; br_en = 1'b0; jmp_en = 1'b0;
    use_imm = 1'b0; fwd_a_en = 1'b0; out_ready = 1'b1;
  endtask

  task automatic apply(output logic fired);
    #1;
    if (rst || flush) exp_q.delete();
    fired = in_valid && in_ready && !rst;
    if (fired)
      exp_q.push_back(model(op, fwd_a_en ? fwd_data : read1, use_imm ? imm : read2,
                            pc_inc, imm, br_en, br_cond, jmp_en));
  endtask

  task automatic idle_cycle();
    logic f;
    @(negedge clk); idle_inputs(); apply(f);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((dbg_state || out_valid || exp_q.size() != 0) && k < 60) begin
      idle_cycle(); k++;
    end
    check("wait_idle_timeout", k < 60, 1);
  endtask

  task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic f;
    int k, low;
    @(negedge clk); idle_inputs();
    op = 3'd7; read1 = a; read2 = b; in_valid = 1'b1;
    apply(f);
    check("mul_accept", f, 1);
    k = 0; low = 0;
    do begin
      idle_cycle(); k++;
      if (!out_valid && !in_ready) low++;
    end while (!out_valid && k < 40);
    check("mul_latency", k, 17);
    check("mul_in_ready_low", low, 16);
  endtask

  task automatic check_zero(input string name);
    check({name, "_valid"}, out_valid, 0);
    check({name, "_result"}, out_result, 0);
    check({name, "_pc_next"}, out_pc_next, 0);
    check({name, "_pc_src"}, out_pc_src, 0);
    check({name, "_ovf"}, out_ovf, 0);
    check({name, "_state"}, dbg_state, 0);
  endtask

  function automatic logic [W-1:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return 16'h7FFF;
      2: return 16'h8000;
      3: return 16'hFFFF;
      default: return W'($urandom());
    endcase
  endfunction

  // Monitor / scoreboard
  initial begin
    logic [EW-1:0] e, got;
    forever begin
      @(negedge clk); #2;
      if (!rst && !flush) begin
        if (!out_valid && out_pc_src) begin
          n_err++;
          $display("FAIL pc_src_qual: got 1 expected 0 while out_valid=0");
        end
        if (out_valid && out_ready) begin
          got = {out_result, out_pc_next, out_pc_src, out_ovf};
          n_vec++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL out_unexpected: got %h expected no result", got);
          end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
              n_err++;
              $display("FAIL out_txn: got res=%h pcn=%h src=%b ovf=%b expected res=%h pcn=%h src=%b ovf=%b",
                       got[EW-1 -: W], got[W+1 -: W], got[1], got[0],
                       e[EW-1 -: W], e[W+1 -: W], e[1], e[0]);
            end
          end
        end
      end
    end
  end

  // Stimulus
  initial begin
    logic f;
    int seen;
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    apply(f);
    check_zero("reset");

    // ADD with signed wrap
    @(negedge clk); idle_inputs();
    op = 3'd0; read1 = 16'h7FFF; read2 = 16'h0001; in_valid = 1'b1;
    apply(f);
    check("add_accept", f, 1);
    idle_cycle();
    check("add_valid", out_valid, 1);
    check("add_result", out_result, 32'h8000);
    check("add_ovf", out_ovf, OVF_ON);
    wait_idle();

    run_mul(16'h0123, 16'h0010);
    wait_idle();
    run_mul(16'hFFFF, 16'hFFFF);
    wait_idle();

    // Branch on forwarded A
    @(negedge clk); idle_inputs();
    op = 3'd0; br_en = 1'b1; br_cond = 2'd2; fwd_a_en = 1'b1; fwd_data = 16'h8000;
    read1 = 16'h0001; read2 = 16'h0002; pc_inc = 16'h0010; imm = 16'hFFF0; in_valid = 1'b1;
    apply(f);
    idle_cycle();
    check("br_pc_src", out_pc_src, 1);
    check("br_pc_next", out_pc_next, 0);
    wait_idle();

    // Output hold, then simultaneous drain and accept
    @(negedge clk); idle_inputs();
    op = 3'd0; read1 = 16'd5; read2 = 16'd3; in_valid = 1'b1; out_ready = 1'b0;
    apply(f);
    check("hold_first_accept", f, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); idle_inputs();
      op = 3'd1; read1 = 16'd9; read2 = 16'd4; in_valid = 1'b1; out_ready = 1'b0;
      apply(f);
      check("hold_no_accept", f, 0);
      check("hold_valid", out_valid, 1);
      check("hold_result", out_result, 8);
    end
    @(negedge clk);
    out_ready = 1'b1;
    apply(f);
    check("swap_accept", f, 1);
    idle_cycle();
    check("swap_valid", out_valid, 1);
    check("swap_result", out_result, 5);
    wait_idle();

    // Flush on MUL cycle 8
    @(negedge clk); idle_inputs();
    op = 3'd7; read1 = 16'd7; read2 = 16'd9; in_valid = 1'b1;
    apply(f);
    repeat (7) idle_cycle();
    @(negedge clk); idle_inputs(); flush = 1'b1;
    apply(f);
    idle_cycle();
    check("flush_state", dbg_state, 0);
    check("flush_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 1);
    seen = 0;
    repeat (20) begin idle_cycle(); if (out_valid) seen++; end
    check("flush_no_result", seen, 0);

    // Reset during MUL, then reset with a held result
    @(negedge clk); idle_inputs();
    op = 3'd7; read1 = 16'h0055; read2 = 16'h0033; in_valid = 1'b1;
    apply(f);
    repeat (5) idle_cycle();
    @(negedge clk); idle_inputs(); rst = 1'b1;
    apply(f);
    @(negedge clk); rst = 1'b0;
    apply(f);
    check_zero("rst_mul");
    @(negedge clk); idle_inputs();
    op = 3'd4; read1 = 16'h1234; read2 = 16'h00FF; in_valid = 1'b1; out_ready = 1'b0;
    apply(f);
    @(negedge clk); idle_inputs(); out_ready = 1'b0;
    apply(f);
    check("rst_hold_valid", out_valid, 1);
    @(negedge clk); rst = 1'b1;
    apply(f);
    @(negedge clk); rst = 1'b0; out_ready = 1'b1;
    apply(f);
    check_zero("rst_hold");

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      idle_inputs();
      flush     = ($urandom_range(0, 59) == 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      op        = 3'($urandom_range(0, 7));
      read1     = rnd_val();
      read2     = rnd_val();
      imm       = rnd_val();
      fwd_data  = rnd_val();
      pc_inc    = W'($urandom());
      use_imm   = 1'($urandom_range(0, 1));
      fwd_a_en  = 1'($urandom_range(0, 1));
      br_cond   = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 3) != 0);
      if (op != 3'd7) begin
        br_en  = ($urandom_range(0, 2) == 0);
        jmp_en = ($urandom_range(0, 6) == 0);
      end
      apply(f);
    end
    wait_idle();
    check("final_queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
